// File: rtl/gpu_pkg.sv
// Shared framebuffer geometry, pixel types and the write-buffer state encoding.
// No timing of its own; the address helper is pure combinational arithmetic.
// No backpressure of its own; users decide how to throttle.
package gpu_pkg;

  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int ADDR_W    = 19;

  typedef logic [9:0]        pix_x_t;
  typedef logic [8:0]        pix_y_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2
  } pwb_state_t;

  // y*640 + x as shift-and-add: (y<<9)+(y<<7)+x. All terms are kept in
  // ADDR_W bits; the largest result (307199) fits without truncation.
  function automatic fb_addr_t fb_linear_addr(input pix_x_t x, input pix_y_t y);
    fb_addr_t yw;
    fb_addr_t xw;
    yw = {{(ADDR_W-9){1'b0}}, y};
    xw = {{(ADDR_W-10){1'b0}}, x};
    return (yw << 9) + (yw << 7) + xw;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; storage plus wrapping pointers.
// Data visible at rd_dat_o one cycle after the push edge; pop takes effect at the edge.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 27
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wr_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rd_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign do_pop   = pop_i && !empty_o;
  assign do_push  = push_i && (!full_o || do_pop);

  // Pointer advance and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pixel_write_buffer.sv
// Filters off-screen rasterizer pixels, queues them and issues acknowledged SRAM word writes.
// Latency: pixel sampled at edge N -> LOAD at N+1 -> mem_wen high after N+2; 2 cycles/pixel best case.
// Backpressure: stop is registered (count >= DEPTH-2); pushes into a full FIFO without a pop set overflow.
module pixel_write_buffer
  import gpu_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               pix_valid,
  input  logic [18:0]        pix_addr,
  input  logic [COLOR_W-1:0] pix_color,
  output logic               stop,
  output logic [18:0]        mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  output logic               mem_wen,
  input  logic               mem_ack,
  output logic               drained,
  output logic               overflow,
  output logic [7:0]         drop_cnt
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int WIDTH = 19 + COLOR_W;

  typedef struct packed {
    pix_x_t             x;
    pix_y_t             y;
    logic [COLOR_W-1:0] color;
  } entry_t;

  entry_t     wr_entry, head;
  pix_x_t     pix_x;
  pix_y_t     pix_y;
  logic       in_range, push_req, off_screen, push_ok, pop;
  logic       fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  pwb_state_t state_q, state_d;
  fb_addr_t   mem_addr_q, mem_addr_d;
  logic [COLOR_W-1:0] mem_wdata_q, mem_wdata_d;
  logic       mem_wen_q, mem_wen_d;
  logic       stop_q, stop_d;
  logic       drained_q, drained_d;
  logic       overflow_q, overflow_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign pix_x      = pix_addr[18:9];
  assign pix_y      = pix_addr[8:0];
  assign in_range   = (pix_x < 10'(FB_WIDTH)) && (pix_y < 9'(FB_HEIGHT));
  assign push_req   = pix_valid && in_range;
  assign off_screen = pix_valid && !in_range;
  // The head is consumed in LOAD; entering LOAD always implies a non-empty FIFO.
  assign pop        = (state_q == LOAD);
  assign push_ok    = push_req && (!fifo_full || pop);
  assign wr_entry   = {pix_addr, pix_color};

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk      (clk),
    .n_rst    (n_rst),
    .push_i   (push_req),
    .wr_dat_i (wr_entry),
    .pop_i    (pop),
    .rd_dat_o (head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: an entry pushed during the ack cycle counts as non-empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = LOAD;
      LOAD:    state_d = WRITE;
      WRITE:   if (mem_ack) state_d = (!fifo_empty || push_ok) ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values: capture the head in LOAD, hold address/data otherwise.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wen_d   = (state_d == WRITE);
    if (state_q == LOAD) begin
      mem_addr_d  = fb_linear_addr(head.x, head.y);
      mem_wdata_d = head.color;
    end
  end

  // Status next-values: throttle, idle indication, sticky overflow, saturating drops.
  always_comb begin
    stop_d     = (fifo_count >= CW'(DEPTH - 2));
    drained_d  = (state_q == IDLE) && fifo_empty;
    overflow_d = overflow_q || (push_req && fifo_full && !pop);
    drop_cnt_d = drop_cnt_q;
    if (off_screen && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Registered outputs; reset abandons any outstanding write.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wen_q   <= 1'b0;
      stop_q      <= 1'b0;
      drained_q   <= 1'b1;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wen_q   <= mem_wen_d;
      stop_q      <= stop_d;
      drained_q   <= drained_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wen   = mem_wen_q;
  assign stop      = stop_q;
  assign drained   = drained_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed bench for pixel_write_buffer: reset, latency, filtering, throttling, overflow, reset mid-write.
// Inputs change 1 time unit after the rising edge; completed writes are logged on the falling edge.
// Every wait on the DUT is bounded and a timeout counts as a failed comparison.
module tb_pixel_write_buffer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        pix_valid;
  logic [18:0] pix_addr;
  logic [7:0]  pix_color;
  logic        stop;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wen;
  logic        mem_ack;
  logic        drained;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  logic [18:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];

  always #5 clk = ~clk;

  pixel_write_buffer #(.DEPTH(8), .COLOR_W(8)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .pix_valid (pix_valid),
    .pix_addr  (pix_addr),
    .pix_color (pix_color),
    .stop      (stop),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_ack   (mem_ack),
    .drained   (drained),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always @(negedge clk) begin
    if (n_rst && mem_wen && mem_ack) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  function automatic logic [18:0] pk(input int x, input int y);
    logic [9:0] xv;
    logic [8:0] yv;
    xv = x[9:0];
    yv = y[8:0];
    return {xv, yv};
  endfunction

  function automatic logic [18:0] lin(input int x, input int y);
    return 19'(y * 640 + x);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input logic [7:0] c);
    pix_valid = 1'b1;
    pix_addr  = pk(x, y);
    pix_color = c;
  endtask

  task automatic do_reset;
    n_rst     = 1'b0;
    pix_valid = 1'b0;
    mem_ack   = 1'b0;
    tick;
    tick;
    n_rst = 1'b1;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic wait_drained(input int budget, output bit ok);
    int n;
    n = 0;
    tick; tick; tick;
    while (!drained && n < budget) begin
      tick;
      n++;
    end
    ok = drained;
  endtask

  task automatic test_reset;
    pix_addr  = '0;
    pix_color = '0;
    do_reset;
    total++; if (mem_wen !== 1'b0)   begin bad++; $display("FAIL rst_wen got %0b want 0", mem_wen); end
    total++; if (mem_addr !== 19'd0) begin bad++; $display("FAIL rst_addr got %0d want 0", mem_addr); end
    total++; if (mem_wdata !== 8'd0) begin bad++; $display("FAIL rst_wdata got %0h want 0", mem_wdata); end
    total++; if (stop !== 1'b0)      begin bad++; $display("FAIL rst_stop got %0b want 0", stop); end
    total++; if (drained !== 1'b1)   begin bad++; $display("FAIL rst_drained got %0b want 1", drained); end
    total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL rst_overflow got %0b want 0", overflow); end
    total++; if (drop_cnt !== 8'd0)  begin bad++; $display("FAIL rst_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_single;
    bit ok;
    do_reset;
    mem_ack = 1'b1;
    drive(3, 2, 8'hA5);
    tick;                       // edge N samples the pixel
    pix_valid = 1'b0;
    total++; if (mem_wen !== 1'b0) begin bad++; $display("FAIL single_wen_n got %0b want 0", mem_wen); end
    tick;                       // N+1: LOAD
    total++; if (mem_wen !== 1'b0) begin bad++; $display("FAIL single_wen_n1 got %0b want 0", mem_wen); end
    tick;                       // N+2: WRITE
    total++; if (mem_wen !== 1'b1) begin bad++; $display("FAIL single_wen_n2 got %0b want 1", mem_wen); end
    total++; if (mem_addr !== 19'd1283) begin bad++; $display("FAIL single_addr got %0d want 1283", mem_addr); end
    total++; if (mem_wdata !== 8'hA5) begin bad++; $display("FAIL single_data got %0h want a5", mem_wdata); end
    wait_drained(30, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_drain got drained=%0b want 1", drained); end
    total++; if (wr_addr_q.size() != 1) begin bad++; $display("FAIL single_count got %0d want 1", wr_addr_q.size()); end
    else begin
      total++; if (wr_addr_q[0] !== 19'd1283 || wr_data_q[0] !== 8'hA5)
        begin bad++; $display("FAIL single_write got %0d/%0h want 1283/a5", wr_addr_q[0], wr_data_q[0]); end
    end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL single_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_offscreen;
    bit ok;
    wr_addr_q.delete();
    wr_data_q.delete();
    mem_ack = 1'b1;
    drive(640, 0, 8'h11); tick;
    drive(0, 480, 8'h22); tick;
    drive(639, 479, 8'h33); tick;
    pix_valid = 1'b0;
    wait_drained(30, ok);
    total++; if (!ok) begin bad++; $display("FAIL off_drain got drained=%0b want 1", drained); end
    total++; if (wr_addr_q.size() != 1) begin bad++; $display("FAIL off_count got %0d want 1", wr_addr_q.size()); end
    else begin
      total++; if (wr_addr_q[0] !== 19'd307199 || wr_data_q[0] !== 8'h33)
        begin bad++; $display("FAIL off_write got %0d/%0h want 307199/33", wr_addr_q[0], wr_data_q[0]); end
    end
    total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL off_drop got %0d want 2", drop_cnt); end
  endtask

  task automatic test_backpressure;
    bit ok;
    int idx;
    int pushed_at_stop;
    do_reset;
    mem_ack = 1'b0;
    idx = 0;
    pushed_at_stop = -1;
    // Count reaches 6 after the 7th push; stop is seen high only after the 8th.
    for (int cyc = 0; cyc < 40 && pushed_at_stop < 0; cyc++) begin
      if (stop) begin
        pushed_at_stop = idx;
        pix_valid = 1'b0;
      end else begin
        drive(20*idx + 7, 11*idx + 3, 8'(8'h60 + idx));
        idx++;
        tick;
      end
    end
    pix_valid = 1'b0;
    total++; if (pushed_at_stop != 8) begin bad++; $display("FAIL bp_stop_point got %0d want 8", pushed_at_stop); end
    repeat (5) tick;
    total++; if (stop !== 1'b1) begin bad++; $display("FAIL bp_stop_held got %0b want 1", stop); end
    total++; if (mem_wen !== 1'b1 || mem_addr !== lin(7, 3))
      begin bad++; $display("FAIL bp_hold got wen=%0b addr=%0d want 1/%0d", mem_wen, mem_addr, lin(7, 3)); end
    mem_ack = 1'b1;
    for (int cyc = 0; cyc < 60 && idx < 10; cyc++) begin
      if (stop) pix_valid = 1'b0;
      else begin
        drive(20*idx + 7, 11*idx + 3, 8'(8'h60 + idx));
        idx++;
      end
      tick;
    end
    pix_valid = 1'b0;
    wait_drained(60, ok);
    total++; if (!ok || idx != 10) begin bad++; $display("FAIL bp_drain got drained=%0b pushed=%0d want 1/10", drained, idx); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_overflow got %0b want 0", overflow); end
    total++; if (wr_addr_q.size() != 10) begin bad++; $display("FAIL bp_count got %0d want 10", wr_addr_q.size()); end
    for (int i = 0; i < 10 && i < wr_addr_q.size(); i++) begin
      total++;
      if (wr_addr_q[i] !== lin(20*i + 7, 11*i + 3) || wr_data_q[i] !== 8'(8'h60 + i)) begin
        bad++;
        $display("FAIL bp_write%0d got %0d/%0h want %0d/%0h", i, wr_addr_q[i], wr_data_q[i],
                 lin(20*i + 7, 11*i + 3), 8'(8'h60 + i));
      end
    end
  endtask

  task automatic test_overflow;
    bit ok;
    do_reset;
    mem_ack = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(30*i + 2, 17*i + 1, 8'(8'h80 + i));
      tick;
    end
    pix_valid = 1'b0;
    tick;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    total++; if (mem_addr !== lin(2, 1)) begin bad++; $display("FAIL ovf_inflight got %0d want %0d", mem_addr, lin(2, 1)); end
    mem_ack = 1'b1;
    wait_drained(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_drain got drained=%0b want 1", drained); end
    total++; if (wr_addr_q.size() != 9) begin bad++; $display("FAIL ovf_count got %0d want 9", wr_addr_q.size()); end
    for (int i = 0; i < 9 && i < wr_addr_q.size(); i++) begin
      total++;
      if (wr_addr_q[i] !== lin(30*i + 2, 17*i + 1) || wr_data_q[i] !== 8'(8'h80 + i)) begin
        bad++;
        $display("FAIL ovf_write%0d got %0d/%0h want %0d/%0h", i, wr_addr_q[i], wr_data_q[i],
                 lin(30*i + 2, 17*i + 1), 8'(8'h80 + i));
      end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
  endtask

  task automatic test_push_pop_full;
    bit ok;
    do_reset;
    mem_ack = 1'b0;
    // Nine pushes: one in flight in WRITE, eight in the FIFO.
    for (int i = 0; i < 9; i++) begin
      drive(40*i + 5, 20*i + 9, 8'(8'hC0 + i));
      tick;
    end
    pix_valid = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ppf_fill_ovf got %0b want 0", overflow); end
    mem_ack = 1'b1;
    tick;                        // ack accepted; FSM moves to LOAD (pop cycle)
    mem_ack = 1'b0;
    drive(40*9 + 5, 20*9 + 9, 8'hC9);
    tick;                        // push into the full FIFO lands on the pop
    pix_valid = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ppf_ovf got %0b want 0", overflow); end
    total++; if (mem_wen !== 1'b1 || mem_addr !== lin(45, 29) || mem_wdata !== 8'hC1)
      begin bad++; $display("FAIL ppf_next got %0b/%0d/%0h want 1/%0d/c1", mem_wen, mem_addr, mem_wdata, lin(45, 29)); end
    total++; if (stop !== 1'b1) begin bad++; $display("FAIL ppf_stop got %0b want 1", stop); end
    mem_ack = 1'b1;
    wait_drained(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL ppf_drain got drained=%0b want 1", drained); end
    total++; if (wr_addr_q.size() != 10) begin bad++; $display("FAIL ppf_count got %0d want 10", wr_addr_q.size()); end
    for (int i = 0; i < 10 && i < wr_addr_q.size(); i++) begin
      total++;
      if (wr_addr_q[i] !== lin(40*i + 5, 20*i + 9) || wr_data_q[i] !== 8'(8'hC0 + i)) begin
        bad++;
        $display("FAIL ppf_write%0d got %0d/%0h want %0d/%0h", i, wr_addr_q[i], wr_data_q[i],
                 lin(40*i + 5, 20*i + 9), 8'(8'hC0 + i));
      end
    end
  endtask

  task automatic test_reset_midwrite;
    do_reset;
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(50*i + 1, 9*i + 2, 8'(8'h10 + i));
      tick;
    end
    pix_valid = 1'b0;
    total++; if (mem_wen !== 1'b1) begin bad++; $display("FAIL rmw_in_write got %0b want 1", mem_wen); end
    wr_addr_q.delete();
    wr_data_q.delete();
    n_rst = 1'b0;
    tick;
    total++; if (mem_wen !== 1'b0)   begin bad++; $display("FAIL rmw_wen got %0b want 0", mem_wen); end
    total++; if (drained !== 1'b1)   begin bad++; $display("FAIL rmw_drained got %0b want 1", drained); end
    total++; if (mem_addr !== 19'd0) begin bad++; $display("FAIL rmw_addr got %0d want 0", mem_addr); end
    total++; if (stop !== 1'b0)      begin bad++; $display("FAIL rmw_stop got %0b want 0", stop); end
    n_rst   = 1'b1;
    mem_ack = 1'b1;
    repeat (20) tick;
    total++; if (wr_addr_q.size() != 0) begin bad++; $display("FAIL rmw_writes got %0d want 0", wr_addr_q.size()); end
    total++; if (mem_wen !== 1'b0 || drained !== 1'b1)
      begin bad++; $display("FAIL rmw_after got wen=%0b drained=%0b want 0/1", mem_wen, drained); end
  endtask

  initial begin
    n_rst     = 1'b0;
    pix_valid = 1'b0;
    pix_addr  = '0;
    pix_color = '0;
    mem_ack   = 1'b0;
    test_reset;
    test_single;
    test_offscreen;
    test_backpressure;
    test_overflow;
    test_push_pop_full;
    test_reset_midwrite;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
